shift_arbiter: RTL and testbench

Arbitrates one shared barrel-shift datapath between two requesters: the execute-stage ALU path (port 0) and the address/immediate path (port 1). Each requester presents an operand, shift amount and operation with a valid/ready handshake. The block grants one request per cycle round-robin, computes the shift, and holds the result in a single-entry output register with its own valid/ready handshake. Rotate/shift logic is internal; no external shifter instance.

---
 rtl/shift_arbiter.sv | 119 +++++++++++
 tb/tb_shift_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of a shared barrel shifter. One request
// is granted per cycle and its result is held in a single-entry output register.
module shift_arbiter #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int SHAMT_WIDTH    = 4,
    parameter int NUM_OPERATIONS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    input  logic [OPERAND_WIDTH-1:0]  req0_in,
    input  logic [SHAMT_WIDTH-1:0]    req0_shamt,
    input  logic [NUM_OPERATIONS-1:0] req0_oper,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [OPERAND_WIDTH-1:0]  req1_in,
    input  logic [SHAMT_WIDTH-1:0]    req1_shamt,
    input  logic [NUM_OPERATIONS-1:0] req1_oper,
    output logic                      req1_ready,
    output logic                      res_valid,
    output logic [OPERAND_WIDTH-1:0]  res_data,
    output logic                      res_id,
    input  logic                      res_ready
);
    localparam int W = OPERAND_WIDTH;

    logic         r_res_valid;
    logic [W-1:0] r_res_data;
    logic         r_res_id;
    logic         r_prio;

    logic                      w_can_accept;
    logic                      w_grant0;
    logic                      w_grant1;
    logic [W-1:0]              w_sel_in;
    logic [SHAMT_WIDTH-1:0]    w_sel_shamt;
    logic [NUM_OPERATIONS-1:0] w_sel_oper;
    logic                      w_right;
    logic                      w_logical;
    logic [W-1:0]              w_rev_in;
    logic [W-1:0]              w_rev_out;
    logic [W-1:0]              w_stage [0:SHAMT_WIDTH];
    logic [W-1:0]              w_shift_out;

    always_comb begin
        w_can_accept = !r_res_valid || res_ready;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        if (!rst && w_can_accept) begin
            w_grant0 = req0_valid && (!req1_valid || !r_prio);
            w_grant1 = req1_valid && (!req0_valid ||  r_prio);
        end
    end

    assign w_sel_in    = w_grant1 ? req1_in    : req0_in;
    assign w_sel_shamt = w_grant1 ? req1_shamt : req0_shamt;
    assign w_sel_oper  = w_grant1 ? req1_oper  : req0_oper;
    assign w_right     = w_sel_oper[1];
    assign w_logical   = w_sel_oper[0];

    // Right-hand ops reuse the left shifter by bit-reversing before and after.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_rev
            assign w_rev_in[gi]  = w_sel_in[W-1-gi];
            assign w_rev_out[gi] = w_stage[SHAMT_WIDTH][W-1-gi];
        end
    endgenerate

    assign w_stage[0] = w_right ? w_rev_in : w_sel_in;

    // Log-depth left shifter: stage gi moves by 2**gi; rotates wrap modulo W.
    generate
        for (gi = 0; gi < SHAMT_WIDTH; gi++) begin : g_stage
            localparam int STEP  = 2 ** gi;
            localparam int ROT_K = STEP % W;
            logic [W-1:0] w_rot;
            logic [W-1:0] w_sll;
            if (ROT_K == 0) begin : g_rot_id
                assign w_rot = w_stage[gi];
            end else begin : g_rot
                assign w_rot = {w_stage[gi][W-1-ROT_K:0], w_stage[gi][W-1:W-ROT_K]};
            end
            if (STEP >= W) begin : g_sll_zero
                assign w_sll = '0;
            end else begin : g_sll
                assign w_sll = {w_stage[gi][W-1-STEP:0], {STEP{1'b0}}};
            end
            assign w_stage[gi+1] = !w_sel_shamt[gi] ? w_stage[gi]
                                 : (w_logical ? w_sll : w_rot);
        end
    endgenerate

    assign w_shift_out = w_right ? w_rev_out : w_stage[SHAMT_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= 1'b0;
            r_prio      <= 1'b0;
        end else if (w_grant0 || w_grant1) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_shift_out;
            r_res_id    <= w_grant1;
            r_prio      <= !w_grant1;
        end else if (res_ready) begin
            // Drain with nothing to refill: data/id keep their last value.
            r_res_valid <= 1'b0;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_id     = r_res_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: a reference shifter fills a scoreboard on
// each observed transfer; results are popped and compared one cycle later.
module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_in, req1_in;
    logic [3:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_oper, req1_oper;
    logic        req0_ready, req1_ready;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_id;
    logic        res_ready;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [16:0] sb [$];
    logic [16:0] exp_e;
    logic        last_xfer0, last_xfer1;

    shift_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_in(req0_in), .req0_shamt(req0_shamt),
        .req0_oper(req0_oper), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_in(req1_in), .req1_shamt(req1_shamt),
        .req1_oper(req1_oper), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // Bit-at-a-time reference shifter.
    function automatic logic [15:0] model_shift(logic [15:0] x, logic [3:0] sh, logic [1:0] op);
        logic [15:0] v = x;
        for (int i = 0; i < int'(sh); i++) begin
            case (op)
                2'b00: v = {v[14:0], v[15]};
                2'b01: v = {v[14:0], 1'b0};
                2'b10: v = {v[0], v[15:1]};
                default: v = {1'b0, v[15:1]};
            endcase
        end
        return v;
    endfunction

    // Advance one cycle; transfers are sampled at the falling edge and scored.
    task automatic tick();
        @(negedge clk);
        last_xfer0 = req0_valid && req0_ready;
        last_xfer1 = req1_valid && req1_ready;
        if (last_xfer0) sb.push_back({1'b0, model_shift(req0_in, req0_shamt, req0_oper)});
        if (last_xfer1) sb.push_back({1'b1, model_shift(req1_in, req1_shamt, req1_oper)});
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp();
        exp_e = (sb.size() != 0) ? sb.pop_front() : 17'bx;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        tick(); tick();
        tests_run++;
        if (res_valid !== 1'b0 || res_data !== 16'h0000 || res_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b d=%h id=%b want v=0 d=0000 id=0", res_valid, res_data, res_id);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        sb.delete();
        rst = 1'b0;
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_in = 16'h8001; req0_shamt = 4'd1; req0_oper = 2'b00;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        pop_exp();
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== 16'h0003 || res_id !== 1'b0 || {res_id, res_data} !== exp_e) begin
            tests_failed++;
            $display("FAIL single_result: got v=%b d=%h id=%b want v=1 d=0003 id=0", res_valid, res_data, res_id);
        end
        $display("[TB] single: req0 8001 rol 1 -> %h id=%0d", res_data, res_id);
    endtask

    task automatic test_ops();
        logic [15:0] t_in  [8] = '{16'h00FF, 16'h0001, 16'h8000, 16'h1234,
                                   16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
        logic [3:0]  t_sh  [8] = '{4'd4, 4'd1, 4'd15, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
        logic [1:0]  t_op  [8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
        logic [15:0] t_exp [8] = '{16'h0FF0, 16'h8000, 16'h0001, 16'h2341,
                                   16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req1_valid = 1'b1; req1_in = t_in[i]; req1_shamt = t_sh[i]; req1_oper = t_op[i];
            #1;
            tests_run++;
            if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL ops_ready[%0d]: got %b%b want 01", i, req0_ready, req1_ready);
            end
            tick();
            pop_exp();
            tests_run++;
            if (res_valid !== 1'b1 || res_id !== 1'b1 || res_data !== t_exp[i] || {res_id, res_data} !== exp_e) begin
                tests_failed++;
                $display("FAIL ops_result[%0d]: got v=%b d=%h id=%b want v=1 d=%h id=1",
                         i, res_valid, res_data, res_id, t_exp[i]);
            end
            $display("[TB] ops[%0d]: %h op=%b sh=%0d -> %h", i, t_in[i], t_op[i], t_sh[i], res_data);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_contention();
        logic exp_g;
        rst = 1'b1; tick(); rst = 1'b0; sb.delete();
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_in = 16'h0F0F; req0_shamt = 4'd3; req0_oper = 2'b00;
        req1_valid = 1'b1; req1_in = 16'hC003; req1_shamt = 4'd2; req1_oper = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = i[0];
            #1;
            tests_run++;
            if (req0_ready !== !exp_g || req1_ready !== exp_g) begin
                tests_failed++;
                $display("FAIL contend_grant[%0d]: got %b%b want grant %0d", i, req0_ready, req1_ready, exp_g);
            end
            tick();
            pop_exp();
            tests_run++;
            if (res_valid !== 1'b1 || res_id !== exp_g || {res_id, res_data} !== exp_e) begin
                tests_failed++;
                $display("FAIL contend_result[%0d]: got v=%b id=%b d=%h want id=%b d=%h",
                         i, res_valid, res_id, res_data, exp_e[16], exp_e[15:0]);
            end
            $display("[TB] contend[%0d]: id=%0d d=%h", i, res_id, res_data);
            if (last_xfer0) begin req0_in = 16'($urandom); req0_shamt = 4'($urandom); req0_oper = 2'($urandom); end
            if (last_xfer1) begin req1_in = 16'($urandom); req1_shamt = 4'($urandom); req1_oper = 2'($urandom); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_in = 16'h00F0; req0_shamt = 4'd2; req0_oper = 2'b01;
        tick();
        pop_exp();
        held = exp_e[15:0];
        req0_in = 16'h1234; req0_shamt = 4'd4; req0_oper = 2'b10;
        res_ready = 1'b0;
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== 16'h03C0 || res_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_first: got v=%b d=%h id=%b want v=1 d=03c0 id=0", res_valid, res_data, res_id);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready);
            end
            tick();
            tests_run++;
            if (res_valid !== 1'b1 || res_data !== held || res_id !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=%h", i, res_valid, res_data, held);
            end
            $display("[TB] bp hold[%0d]: d=%h", i, res_data);
        end
        res_ready = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        pop_exp();
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== 16'h4123 || {res_id, res_data} !== exp_e) begin
            tests_failed++;
            $display("FAIL bp_refill: got v=%b d=%h want v=1 d=4123", res_valid, res_data);
        end
        $display("[TB] bp refill: d=%h", res_data);
        tick();
        tests_run++;
        if (res_valid !== 1'b0 || res_data !== 16'h4123) begin
            tests_failed++;
            $display("FAIL drain: got v=%b d=%h want v=0 d=4123", res_valid, res_data);
        end
        tick();
        tests_run++;
        if (res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_ready: got v=%b want 0", res_valid);
        end
        $display("[TB] drain: v=%b d=%h", res_valid, res_data);
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        req1_valid = 1'b1; req1_in = 16'hF00F; req1_shamt = 4'd4; req1_oper = 2'b00;
        tick();
        req1_valid = 1'b0; res_ready = 1'b0;
        pop_exp();
        tests_run++;
        if (res_valid !== 1'b1 || {res_id, res_data} !== exp_e) begin
            tests_failed++;
            $display("FAIL rmid_setup: got v=%b id=%b d=%h want v=1 id=%b d=%h",
                     res_valid, res_id, res_data, exp_e[16], exp_e[15:0]);
        end
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_in = 16'h0001; req0_shamt = 4'd15; req0_oper = 2'b00;
        #1;
        tests_run++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        tick();
        sb.delete();
        tests_run++;
        if (res_valid !== 1'b0 || res_data !== 16'h0000 || res_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_state: got v=%b d=%h id=%b want v=0 d=0000 id=0", res_valid, res_data, res_id);
        end
        rst = 1'b0; res_ready = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_prio: got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        pop_exp();
        tests_run++;
        if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 16'h8000 || {res_id, res_data} !== exp_e) begin
            tests_failed++;
            $display("FAIL rmid_result: got v=%b id=%b d=%h want v=1 id=0 d=8000", res_valid, res_id, res_data);
        end
        $display("[TB] reset-mid: first grant id=%0d d=%h", res_id, res_data);
    endtask

    initial begin
        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b0; req0_in = '0; req0_shamt = '0; req0_oper = '0;
        req1_valid = 1'b0; req1_in = '0; req1_shamt = '0; req1_oper = '0;
        last_xfer0 = 1'b0; last_xfer1 = 1'b0;
        test_reset();
        test_single();
        test_ops();
        test_contention();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
